// File: rtl/fir_sig_check.sv
// MISR response checker for the FIR test flow: samples outData once per stimulus
// period, compacts NUM_VECTORS samples into a signature and reports done/pass.
module fir_sig_check #(
    parameter int              WIDTH         = 32,
    parameter int              PERIOD        = 31,
    parameter int              SAMPLE_OFFSET = 30,
    parameter int              WARMUP        = 1,
    parameter int              NUM_VECTORS   = 256,
    parameter logic [WIDTH-1:0] POLY         = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED         = 32'hFFFFFFFF,
    parameter logic [WIDTH-1:0] GOLDEN       = 32'h00000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] outData,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      vec_count,
    output logic             done,
    output logic             pass
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] LAST_PH   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] SAMPLE_PH = PW'(SAMPLE_OFFSET);
    localparam logic [15:0]   WARM_LAST = 16'(WARMUP - 1);
    localparam logic [15:0]   VEC_LAST  = 16'(NUM_VECTORS);

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;

    // One MISR compaction step: shift, conditional polynomial feedback, data XOR.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] fb;
        fb = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
        return {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
    endfunction

    logic [PW-1:0]    phase_r;
    state_t           state_r,     state_s;
    logic [15:0]      warm_cnt_r,  warm_cnt_s;
    logic [WIDTH-1:0] sig_r,       sig_s;
    logic [15:0]      vec_count_r, vec_count_s;
    logic             done_r,      done_s;
    logic             pass_r,      pass_s;
    logic             sample_s;
    logic [WIDTH-1:0] sig_step_s;

    assign sample_s   = (phase_r == SAMPLE_PH);
    assign sig_step_s = misr_step(sig_r, outData);

    // Phase counter tracking the stimulus generator's cycle count.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= {PW{1'b0}};
        end else if (phase_r == LAST_PH) begin
            phase_r <= {PW{1'b0}};
        end else begin
            phase_r <= phase_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and next-value logic for warm-up, compaction and completion.
    always_comb begin
        state_s     = state_r;
        warm_cnt_s  = warm_cnt_r;
        sig_s       = sig_r;
        vec_count_s = vec_count_r;
        done_s      = done_r;
        pass_s      = pass_r;
        case (state_r)
            ST_WARM: begin
                if (sample_s) begin
                    warm_cnt_s = warm_cnt_r + 16'd1;
                    if (warm_cnt_r == WARM_LAST) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_WARM;
                    end
                end else begin
                    state_s = ST_WARM;
                end
            end
            ST_RUN: begin
                if (sample_s) begin
                    sig_s       = sig_step_s;
                    vec_count_s = vec_count_r + 16'd1;
                    // Completion and verdict land on the same edge as the last sample.
                    if (vec_count_s == VEC_LAST) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        pass_s  = (sig_step_s == GOLDEN);
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = RESET_STATE;
            end
        endcase
    end

    // State and result registers; everything is frozen once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RESET_STATE;
            warm_cnt_r  <= 16'd0;
            sig_r       <= SEED;
            vec_count_r <= 16'd0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            warm_cnt_r  <= warm_cnt_s;
            sig_r       <= sig_s;
            vec_count_r <= vec_count_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
        end
    end

    assign signature = sig_r;
    assign vec_count = vec_count_r;
    assign done      = done_r;
    assign pass      = pass_r;

endmodule

// File: tb/tb_fir_sig_check.sv
// Self-checking bench for fir_sig_check: parameter variants run side by side,
// randomized data checked against a plain-arithmetic MISR model.
module tb_fir_sig_check;

    localparam logic [31:0] POLY_C    = 32'h04C11DB7;
    localparam logic [31:0] GOLD_FULL = 32'h1234_5678;
    localparam logic [31:0] GOLD_FLIP = 32'h1234_5679;

    logic        clk;
    logic        rst;
    logic [31:0] data_def, data_a, data_b, data_c;

    logic [31:0] sig_full, sig_flip, sig_a, sig_b, sig_c;
    logic [15:0] vc_full, vc_flip, vc_a, vc_b, vc_c;
    logic        done_full, done_flip, done_a, done_b, done_c;
    logic        pass_full, pass_flip, pass_a, pass_b, pass_c;

    int checks = 0;
    int errors = 0;

    fir_sig_check #(.GOLDEN(GOLD_FULL)) dut_full (
        .clk(clk), .rst(rst), .outData(data_def), .signature(sig_full),
        .vec_count(vc_full), .done(done_full), .pass(pass_full));

    fir_sig_check #(.GOLDEN(GOLD_FLIP)) dut_flip (
        .clk(clk), .rst(rst), .outData(data_def), .signature(sig_flip),
        .vec_count(vc_flip), .done(done_flip), .pass(pass_flip));

    fir_sig_check #(.SEED(32'h1), .WARMUP(0), .NUM_VECTORS(1), .GOLDEN(32'h2)) dut_a (
        .clk(clk), .rst(rst), .outData(data_a), .signature(sig_a),
        .vec_count(vc_a), .done(done_a), .pass(pass_a));

    fir_sig_check #(.SEED(32'h80000000), .WARMUP(0), .NUM_VECTORS(1), .GOLDEN(32'h0)) dut_b (
        .clk(clk), .rst(rst), .outData(data_b), .signature(sig_b),
        .vec_count(vc_b), .done(done_b), .pass(pass_b));

    fir_sig_check #(.SEED(32'h1), .WARMUP(1), .NUM_VECTORS(1), .GOLDEN(32'h2)) dut_c (
        .clk(clk), .rst(rst), .outData(data_c), .signature(sig_c),
        .vec_count(vc_c), .done(done_c), .pass(pass_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compaction: multiply-by-x modulo POLY, then add the sample.
    function automatic logic [31:0] model_next(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] fb;
        fb = s[31] ? POLY_C : 32'h0;
        return (s << 1) ^ fb ^ d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        data_def = 32'hDEADBEEF;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sig_full !== 32'hFFFFFFFF || vc_full !== 16'd0 || done_full !== 1'b0 || pass_full !== 1'b0) begin
                errors++;
                $display("FAIL reset_during: sig=%h vc=%0d done=%b pass=%b, want ffffffff 0 0 0",
                         sig_full, vc_full, done_full, pass_full);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            checks++;
            if (sig_full !== 32'hFFFFFFFF || vc_full !== 16'd0 || done_full !== 1'b0 || pass_full !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: sig=%h vc=%0d done=%b pass=%b, want ffffffff 0 0 0",
                         n, sig_full, vc_full, done_full, pass_full);
            end
        end
    endtask

    task automatic test_single_shift();
        data_a = 32'h0;
        reset_all();
        repeat (30) tick();
        checks++;
        if (vc_a !== 16'd0 || done_a !== 1'b0 || sig_a !== 32'h1) begin
            errors++;
            $display("FAIL shift_early: sig=%h vc=%0d done=%b, want 00000001 0 0", sig_a, vc_a, done_a);
        end
        tick();
        checks++;
        if (sig_a !== 32'h2 || vc_a !== 16'd1 || done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++;
            $display("FAIL shift_result: sig=%h vc=%0d done=%b pass=%b, want 00000002 1 1 1",
                     sig_a, vc_a, done_a, pass_a);
        end
        repeat (100) begin
            data_a = $urandom;
            tick();
        end
        checks++;
        if (sig_a !== 32'h2 || vc_a !== 16'd1 || done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++;
            $display("FAIL shift_frozen: sig=%h vc=%0d done=%b pass=%b, want 00000002 1 1 1",
                     sig_a, vc_a, done_a, pass_a);
        end
    endtask

    task automatic test_feedback();
        data_b = 32'h1;
        reset_all();
        repeat (31) tick();
        checks++;
        if (sig_b !== 32'h04C11DB6 || done_b !== 1'b1 || pass_b !== 1'b0 || vc_b !== 16'd1) begin
            errors++;
            $display("FAIL feedback: sig=%h vc=%0d done=%b pass=%b, want 04c11db6 1 1 0",
                     sig_b, vc_b, done_b, pass_b);
        end
    endtask

    task automatic test_warmup();
        data_c = 32'hFFFFFFFF;
        reset_all();
        repeat (31) tick();
        data_c = 32'h0;
        checks++;
        if (sig_c !== 32'h1 || vc_c !== 16'd0 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL warm_discard: sig=%h vc=%0d done=%b, want 00000001 0 0", sig_c, vc_c, done_c);
        end
        repeat (31) tick();
        checks++;
        if (sig_c !== 32'h2 || vc_c !== 16'd1 || done_c !== 1'b1 || pass_c !== 1'b1) begin
            errors++;
            $display("FAIL warm_result: sig=%h vc=%0d done=%b pass=%b, want 00000002 1 1 1",
                     sig_c, vc_c, done_c, pass_c);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        reset_all();
        repeat (1000) begin
            data_def = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sig_full !== 32'hFFFFFFFF || vc_full !== 16'd0 || done_full !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: sig=%h vc=%0d done=%b, want ffffffff 0 0", sig_full, vc_full, done_full);
        end
        for (int n = 1; n <= 61; n++) begin
            data_def = $urandom;
            tick();
        end
        checks++;
        if (sig_full !== 32'hFFFFFFFF || vc_full !== 16'd0) begin
            errors++;
            $display("FAIL midreset_warm: sig=%h vc=%0d, want ffffffff 0", sig_full, vc_full);
        end
        d = $urandom;
        data_def = d;
        tick();
        checks++;
        if (sig_full !== model_next(32'hFFFFFFFF, d) || vc_full !== 16'd1) begin
            errors++;
            $display("FAIL midreset_first: sig=%h vc=%0d, want %h 1", sig_full, vc_full, model_next(32'hFFFFFFFF, d));
        end
    endtask

    task automatic test_full_run();
        logic [31:0] model;
        logic [31:0] d;
        int          j;
        reset_all();
        model = 32'hFFFFFFFF;
        for (int n = 1; n <= 7967; n++) begin
            j = n / 31;
            if (n % 31 == 0 && j == 257) begin
                // Steer the final sample so the signature lands on the golden value.
                d = (model << 1) ^ (model[31] ? POLY_C : 32'h0) ^ GOLD_FULL;
            end else begin
                d = $urandom;
            end
            data_def = d;
            tick();
            if (n % 31 == 0) begin
                if (j >= 2) model = model_next(model, d);
                checks++;
                if (sig_full !== model || vc_full !== 16'(j - 1)) begin
                    errors++;
                    $display("FAIL full_sample %0d: sig=%h vc=%0d, want %h %0d", j, sig_full, vc_full, model, j - 1);
                end
            end
            if (n == 7966) begin
                checks++;
                if (done_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_done_early: done=%b, want 0", done_full);
                end
            end
        end
        checks++;
        if (done_full !== 1'b1 || pass_full !== 1'b1 || vc_full !== 16'd256 || sig_full !== GOLD_FULL) begin
            errors++;
            $display("FAIL full_pass: done=%b pass=%b vc=%0d sig=%h, want 1 1 256 %h",
                     done_full, pass_full, vc_full, sig_full, GOLD_FULL);
        end
        checks++;
        if (done_flip !== 1'b1 || pass_flip !== 1'b0 || sig_flip !== GOLD_FULL) begin
            errors++;
            $display("FAIL full_flip: done=%b pass=%b sig=%h, want 1 0 %h", done_flip, pass_flip, sig_flip, GOLD_FULL);
        end
        repeat (100) begin
            data_def = $urandom;
            tick();
        end
        checks++;
        if (done_full !== 1'b1 || pass_full !== 1'b1 || vc_full !== 16'd256 || sig_full !== GOLD_FULL) begin
            errors++;
            $display("FAIL full_frozen: done=%b pass=%b vc=%0d sig=%h, want 1 1 256 %h",
                     done_full, pass_full, vc_full, sig_full, GOLD_FULL);
        end
    endtask

    initial begin
        rst      = 1'b1;
        data_def = 32'h0;
        data_a   = 32'h0;
        data_b   = 32'h0;
        data_c   = 32'h0;
        test_reset();
        test_single_shift();
        test_feedback();
        test_warmup();
        test_mid_reset();
        test_full_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
